wb_trace_buffer: RTL and testbench

- Hardware counterpart to the simulation-only commit monitor: captures processor commit events into an on-chip FIFO and drains them through a valid/ready read port.
- Events captured: register writeback, data-memory read, data-memory write.
- Sits beside the pipelined MIPS core and taps the MEM-stage and WB-stage control/data signals.
- Lets a host or debug unit read the execution trace without simulator access.

---
 rtl/mips_trace_pkg.sv | 32 +++
 rtl/trace_fifo_2w1r.sv | 75 +++++++
 rtl/wb_trace_buffer.sv | 118 +++++++++++
 tb/tb_wb_trace_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared definitions for the commit-trace buffer: entry layout, event kinds
// and the helper that assembles one FIFO entry from its fields.
package mips_trace_pkg;

    localparam int TRACE_W = 71;

    localparam int VALUE_LSB = 0;
    localparam int VALUE_W   = 32;
    localparam int PC_LSB    = 32;
    localparam int PC_W      = 32;
    localparam int REG_LSB   = 64;
    localparam int REG_W     = 5;
    localparam int KIND_LSB  = 69;
    localparam int KIND_W    = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_REG = 2'b00,
        KIND_MRD = 2'b01,
        KIND_MWR = 2'b10
    } trace_kind_e;

    // Entry layout, MSB first: kind | reg | pc | value
    function automatic logic [TRACE_W-1:0] pack_entry(
        input trace_kind_e        kind,
        input logic [REG_W-1:0]   rg,
        input logic [PC_W-1:0]    pc,
        input logic [VALUE_W-1:0] value
    );
        return {kind, rg, pc, value};
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Generic first-word-fall-through FIFO with two write ports and one read
// port. Port A is always the older of the two pushes in a cycle. Space is
// judged from the occupancy at the start of the cycle, so a same-cycle pop
// never makes room for that cycle's pushes.
module trace_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int W     = 71,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push_a,
    input  logic [W-1:0]  data_a,
    input  logic          push_b,
    input  logic [W-1:0]  data_b,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  data,
    output logic [LW-1:0] free,
    output logic          accept_a,
    output logic          accept_b
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [AW-1:0] wr_ptr_b;
    logic [1:0]    n_push;
    logic          pop;

    // Admission: A needs one free slot, B needs one more beyond whatever A took
    always_comb begin
        free     = LW'(DEPTH) - count;
        accept_a = push_a && !clear && (free != '0);
        accept_b = push_b && !clear &&
                   (free >= (accept_a ? LW'(2) : LW'(1)));
        n_push   = {1'b0, accept_a} + {1'b0, accept_b};
        wr_ptr_b = wr_ptr + AW'(accept_a);
        valid    = (count != '0);
        pop      = valid && ready && !clear;
        data     = valid ? mem[rd_ptr] : '0;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + LW'(n_push) - LW'(pop);
        end
    end

    // Storage array; contents are only visible through the occupancy gate
    always_ff @(posedge clk) begin
        if (accept_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (accept_b) begin
            mem[wr_ptr_b] <= data_b;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture beside the pipelined MIPS core. Turns WB-stage register
// writes and MEM-stage loads/stores into trace entries, queues them in a
// dual-push FIFO and hands them out through a valid/ready port.
module wb_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FILTER_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       wb_reg_write,
    input  logic [4:0]                 wb_reg_addr,
    input  logic [31:0]                wb_data,
    input  logic [31:0]                wb_pc,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                mem_rdata,
    input  logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_pc,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [TRACE_W-1:0]         trace_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       proto_err
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic               wb_event;
    logic               mem_event;
    logic [TRACE_W-1:0] wb_entry;
    logic [TRACE_W-1:0] mem_entry;
    logic               push_a;
    logic               push_b;
    logic [TRACE_W-1:0] data_a;
    logic [TRACE_W-1:0] data_b;
    logic               accept_a;
    logic               accept_b;
    logic [LW-1:0]      free;
    logic [1:0]         dropped;
    logic [CNT_W:0]     drop_sum;

    // Event detection and ordering: the WB instruction is older, so it takes port A
    always_comb begin
        wb_event  = enable && wb_reg_write &&
                    !((FILTER_ZERO != 0) && (wb_reg_addr == 5'd0));
        mem_event = enable && (mem_read || mem_write);
        wb_entry  = pack_entry(KIND_REG, wb_reg_addr, wb_pc, wb_data);
        mem_entry = mem_write ? pack_entry(KIND_MWR, 5'd0, mem_pc, mem_wdata)
                              : pack_entry(KIND_MRD, 5'd0, mem_pc, mem_rdata);
        push_a    = 1'b0;
        push_b    = 1'b0;
        data_a    = wb_entry;
        data_b    = mem_entry;
        if (!clear) begin
            if (wb_event) begin
                push_a = 1'b1;
                push_b = mem_event;
            end else begin
                push_a = mem_event;
                data_a = mem_entry;
            end
        end
        dropped  = {1'b0, push_a && !accept_a} + {1'b0, push_b && !accept_b};
        drop_sum = {1'b0, drop_count} + (CNT_W+1)'(dropped);
        level    = LW'(DEPTH) - free;
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (TRACE_W),
        .LW    (LW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push_a   (push_a),
        .data_a   (data_a),
        .push_b   (push_b),
        .data_b   (data_b),
        .ready    (trace_ready),
        .valid    (trace_valid),
        .data     (trace_data),
        .free     (free),
        .accept_a (accept_a),
        .accept_b (accept_b)
    );

    // Saturating count of events turned away by a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (drop_sum[CNT_W]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum[CNT_W-1:0];
        end
    end

    // Sticky flag for a load and a store claimed by the same MEM-stage instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (clear) begin
            proto_err <= 1'b0;
        end else if (enable && mem_read && mem_write) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue scoreboard of expected
// FIFO contents and a small occupancy/drop/error model.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic        trace_valid;
    logic        trace_ready;
    logic [70:0] trace_data;
    logic [4:0]  level;
    logic [15:0] drop_count;
    logic        proto_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [70:0] expq[$];
    int          mlevel   = 0;
    int          mdrop    = 0;
    logic        mperr    = 1'b0;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .DEPTH       (16),
        .FILTER_ZERO (1),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear        (clear),
        .wb_reg_write (wb_reg_write),
        .wb_reg_addr  (wb_reg_addr),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_pc       (mem_pc),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_data   (trace_data),
        .level        (level),
        .drop_count   (drop_count),
        .proto_err    (proto_err)
    );

    task automatic checkOutput(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        enable       = 1'b1;
        clear        = 1'b0;
        wb_reg_write = 1'b0;
        wb_reg_addr  = '0;
        wb_data      = '0;
        wb_pc        = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_rdata    = '0;
        mem_wdata    = '0;
        mem_pc       = '0;
        trace_ready  = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_level"}, 71'(level), 71'(mlevel));
        checkOutput({tag, "_valid"}, 71'(trace_valid), 71'(mlevel != 0));
        checkOutput({tag, "_drop"}, 71'(drop_count), 71'(mdrop));
        checkOutput({tag, "_perr"}, 71'(proto_err), 71'(mperr));
        checkOutput({tag, "_head"}, trace_data, (expq.size() > 0) ? expq[0] : 71'd0);
    endtask

    // One clock of stimulus; the model is updated from what was driven
    task automatic applyStimulus(
        input string       tag,
        input logic        en, clr, wbw,
        input logic [4:0]  wra,
        input logic [31:0] wd, wpc,
        input logic        mr, mw,
        input logic [31:0] mrd, mwd, mpc,
        input logic        rdy
    );
        logic [70:0] ev[$];
        int          free;
        enable       = en;
        clear        = clr;
        wb_reg_write = wbw;
        wb_reg_addr  = wra;
        wb_data      = wd;
        wb_pc        = wpc;
        mem_read     = mr;
        mem_write    = mw;
        mem_rdata    = mrd;
        mem_wdata    = mwd;
        mem_pc       = mpc;
        trace_ready  = rdy;
        if (rdy && !clr && mlevel > 0) checkOutput({tag, "_pop"}, trace_data, expq[0]);
        free = 16 - mlevel;
        if (clr) begin
            expq.delete();
            mlevel = 0;
            mdrop  = 0;
            mperr  = 1'b0;
        end else begin
            if (en && wbw && wra != 5'd0) ev.push_back({2'b00, wra, wpc, wd});
            if (en && (mr || mw)) ev.push_back(mw ? {2'b10, 5'd0, mpc, mwd} : {2'b01, 5'd0, mpc, mrd});
            if (rdy && mlevel > 0) begin
                void'(expq.pop_front());
                mlevel--;
            end
            for (int i = 0; i < ev.size(); i++) begin
                if (i < free) begin
                    expq.push_back(ev[i]);
                    mlevel++;
                end else begin
                    mdrop = (mdrop == 65535) ? 65535 : mdrop + 1;
                end
            end
            if (en && mr && mw) mperr = 1'b1;
        end
        @(posedge clk);
        #1;
        idleInputs();
        checkState(tag);
    endtask

    task automatic wbEvent(input string tag, input logic [4:0] ra, input logic [31:0] d, input logic [31:0] pc);
        applyStimulus(tag, 1'b1, 1'b0, 1'b1, ra, d, pc, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic dualEvent(input string tag, input logic [4:0] ra, input logic [31:0] d,
                             input logic [31:0] pc, input logic [31:0] rd, input logic rdy);
        applyStimulus(tag, 1'b1, 1'b0, 1'b1, ra, d, pc, 1'b1, 1'b0, rd, 32'd0, pc + 32'd4, rdy);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        end
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single register writeback appears one cycle later
        wbEvent("t1", 5'd8, 32'd5, 32'h10);
        checkOutput("t1_entry", trace_data, {2'b00, 5'd8, 32'h10, 32'd5});
        drain("t1_drain", 1);

        // WB and MEM in the same cycle: WB first, then MRD
        applyStimulus("t2", 1'b1, 1'b0, 1'b1, 5'd9, 32'd7, 32'h14, 1'b1, 1'b0, 32'd42, 32'd0, 32'h18, 1'b0);
        checkOutput("t2_level", 71'(level), 71'd2);
        drain("t2_drain", 1);
        checkOutput("t2_second", trace_data, {2'b01, 5'd0, 32'h18, 32'd42});
        drain("t2_drain", 1);

        // Fill under backpressure: 1 + 7*2 = 15, then one slot for 2 events
        wbEvent("t3_first", 5'd1, 32'h100, 32'h40);
        for (int i = 0; i < 8; i++) begin
            dualEvent("t3_fill", 5'(i + 2), 32'h200 + 32'(i), 32'h80 + 32'(8 * i), 32'h300 + 32'(i), 1'b0);
        end
        checkOutput("t3_full_level", 71'(level), 71'd16);
        checkOutput("t3_drop_one", 71'(drop_count), 71'd1);
        checkOutput("t3_head_kept", trace_data, {2'b00, 5'd1, 32'h40, 32'h100});
        dualEvent("t3_over", 5'd20, 32'h400, 32'hC0, 32'h500, 1'b0);
        checkOutput("t3_drop_three", 71'(drop_count), 71'd3);
        dualEvent("t3_full_pop", 5'd21, 32'h401, 32'hD0, 32'h501, 1'b1);
        checkOutput("t3_pop_level", 71'(level), 71'd15);
        checkOutput("t3_drop_five", 71'(drop_count), 71'd5);
        drain("t3_drain", 15);

        // Capture disabled: nothing stored, nothing counted
        applyStimulus("t4_disabled", 1'b0, 1'b0, 1'b1, 5'd3, 32'd1, 32'h60, 1'b1, 1'b0, 32'd2, 32'd0, 32'h64, 1'b0);

        // Register 0 filtered; conflicting strobes keep only the store
        wbEvent("t5_r0", 5'd0, 32'hDEAD, 32'h70);
        checkOutput("t5_r0_level", 71'(level), 71'd0);
        applyStimulus("t5_conflict", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd9, 32'd3, 32'h74, 1'b0);
        checkOutput("t5_mwr", trace_data, {2'b10, 5'd0, 32'h74, 32'd3});
        checkOutput("t5_perr", 71'(proto_err), 71'd1);
        drain("t5_drain", 1);

        // Clear wins over a same-cycle event
        for (int i = 0; i < 5; i++) wbEvent("t6_fill", 5'(i + 10), 32'(i), 32'h90 + 32'(4 * i));
        checkOutput("t6_level5", 71'(level), 71'd5);
        applyStimulus("t6_clear", 1'b1, 1'b1, 1'b1, 5'd15, 32'd77, 32'hA0, 1'b1, 1'b0, 32'd8, 32'd0, 32'hA4, 1'b1);
        checkOutput("t6_valid0", 71'(trace_valid), 71'd0);
        checkOutput("t6_perr0", 71'(proto_err), 71'd0);

        // Async reset in the middle of a drain
        for (int i = 0; i < 4; i++) wbEvent("t7_fill", 5'(i + 4), 32'h50 + 32'(i), 32'hB0 + 32'(4 * i));
        drain("t7_drain", 1);
        trace_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t7_rst_valid", 71'(trace_valid), 71'd0);
        checkOutput("t7_rst_data", trace_data, 71'd0);
        checkOutput("t7_rst_level", 71'(level), 71'd0);
        expq.delete();
        mlevel = 0;
        mdrop  = 0;
        mperr  = 1'b0;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
        checkState("t7_after_reset");
        wbEvent("t7_resume", 5'd30, 32'h1234, 32'hF0);
        checkOutput("t7_resume_entry", trace_data, {2'b00, 5'd30, 32'hF0, 32'h1234});
        drain("t7_final", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
